regfile_mp: RTL and testbench

Parametrised multi-port register file with write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 3-read/1-write CPU register file in the decode stage. NumRead registered read ports feed operand latches. NumWrite write ports accept writeback from independent units (ALU, load). Busy bits mark registers whose value is pending from an outstanding load, so the hazard unit can stall.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wsel.sv | 35 +++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and port-slicing helper for the multi-port register file.
package regfile_pkg;
    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 5;
    localparam int MAX_READ  = 4;
    localparam int MAX_WRITE = 2;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/regfile_wsel.sv
// Resolves the committing write ports against one address: hit flag plus
// winning data, highest port index wins, register 0 masked when ZeroReg=1.
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int DataSize = DATA_SIZE,
    parameter int AddrSize = ADDR_SIZE,
    parameter int NumWrite = 2,
    parameter int ZeroReg  = 1
) (
    input  logic                         enable,
    input  logic [NumWrite-1:0]          do_write,
    input  logic [NumWrite*AddrSize-1:0] write_addr,
    input  logic [NumWrite*DataSize-1:0] write_data,
    input  logic [AddrSize-1:0]          addr,
    output logic                         hit,
    output logic [DataSize-1:0]          data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so a later (higher) port overrides an earlier one.
        for (int j = 0; j < NumWrite; j++) begin
            if (enable && do_write[j] &&
                write_addr[slice_lo(j, AddrSize) +: AddrSize] == addr) begin
                hit  = 1'b1;
                data = write_data[slice_lo(j, DataSize) +: DataSize];
            end
        end
        if (ZeroReg != 0 && addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port flop-based register file with write-to-read bypass and a
// per-register busy scoreboard for outstanding loads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DataSize = DATA_SIZE,
    parameter int AddrSize = ADDR_SIZE,
    parameter int NumRead  = 3,
    parameter int NumWrite = 2,
    parameter int ZeroReg  = 1,
    parameter int Bypass   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable_reg_fetch,
    input  logic [NumRead*AddrSize-1:0]  read_addr,
    output logic [NumRead*DataSize-1:0]  read_data,
    output logic [NumRead-1:0]           read_busy,
    input  logic                         enable_reg_write,
    input  logic [NumWrite-1:0]          do_reg_write,
    input  logic [NumWrite*AddrSize-1:0] write_reg_addr,
    input  logic [NumWrite*DataSize-1:0] write_reg_data,
    input  logic                         mark_busy,
    input  logic [AddrSize-1:0]          mark_addr,
    output logic [(2**AddrSize)-1:0]     busy_vec
);
    localparam int Depth = 2 ** AddrSize;

    logic [Depth-1:0][DataSize-1:0]   mem;
    logic [Depth-1:0][DataSize-1:0]   ent_data;
    logic [Depth-1:0]                 ent_hit;
    logic [Depth-1:0]                 busy;
    logic [Depth-1:0]                 busy_nxt;

    logic [NumRead-1:0][DataSize-1:0] byp_data;
    logic [NumRead-1:0][DataSize-1:0] rd_val;
    logic [NumRead-1:0]               byp_hit;
    logic [NumRead-1:0]               rb_val;

    for (genvar e = 0; e < Depth; e++) begin : g_ent
        regfile_wsel #(
            .DataSize(DataSize), .AddrSize(AddrSize),
            .NumWrite(NumWrite), .ZeroReg(ZeroReg)
        ) u_wsel (
            .enable    (enable_reg_write),
            .do_write  (do_reg_write),
            .write_addr(write_reg_addr),
            .write_data(write_reg_data),
            .addr      (AddrSize'(e)),
            .hit       (ent_hit[e]),
            .data      (ent_data[e])
        );

        // A fresh mark beats a same-cycle clear: the new load supersedes.
        assign busy_nxt[e] = (ZeroReg != 0 && e == 0)              ? 1'b0 :
                             (mark_busy && mark_addr == AddrSize'(e)) ? 1'b1 :
                             ent_hit[e]                             ? 1'b0 : busy[e];
    end

    for (genvar k = 0; k < NumRead; k++) begin : g_rd
        logic [AddrSize-1:0] raddr;
        assign raddr = read_addr[k*AddrSize +: AddrSize];

        regfile_wsel #(
            .DataSize(DataSize), .AddrSize(AddrSize),
            .NumWrite(NumWrite), .ZeroReg(ZeroReg)
        ) u_byp (
            .enable    (enable_reg_write),
            .do_write  (do_reg_write),
            .write_addr(write_reg_addr),
            .write_data(write_reg_data),
            .addr      (raddr),
            .hit       (byp_hit[k]),
            .data      (byp_data[k])
        );

        // Busy follows the data source: next-state with bypass, current without.
        always_comb begin
            rd_val[k] = (Bypass != 0 && byp_hit[k]) ? byp_data[k] : mem[raddr];
            rb_val[k] = (Bypass != 0) ? busy_nxt[raddr] : busy[raddr];
            if (ZeroReg != 0 && raddr == '0) begin
                rd_val[k] = '0;
                rb_val[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            for (int e = 0; e < Depth; e++) begin
                if (ent_hit[e]) mem[e] <= ent_data[e];
            end
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= '0;
            read_busy <= '0;
        end else if (enable_reg_fetch) begin
            read_data <= rd_val;
            read_busy <= rb_val;
        end
    end

    assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: Bypass=1 and Bypass=0 instances share stimulus.
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_reg_fetch;
    logic [14:0] read_addr;
    logic [95:0] read_data, read_data_nb;
    logic [2:0]  read_busy, read_busy_nb;
    logic        enable_reg_write;
    logic [1:0]  do_reg_write;
    logic [9:0]  write_reg_addr;
    logic [63:0] write_reg_data;
    logic        mark_busy;
    logic [4:0]  mark_addr;
    logic [31:0] busy_vec, busy_vec_nb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string            name;
        logic [2:0][31:0] d;
        logic [2:0]       b;
        bit               chk;
    } exp_t;

    exp_t q_byp[$];
    exp_t q_nb[$];
    logic fq;

    always #5 clock = ~clock;

    regfile_mp #(.NumRead(3), .NumWrite(2), .ZeroReg(1), .Bypass(1)) dut (
        .clock(clock), .reset(reset), .enable_reg_fetch(enable_reg_fetch),
        .read_addr(read_addr), .read_data(read_data), .read_busy(read_busy),
        .enable_reg_write(enable_reg_write), .do_reg_write(do_reg_write),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .mark_busy(mark_busy), .mark_addr(mark_addr), .busy_vec(busy_vec)
    );

    regfile_mp #(.NumRead(3), .NumWrite(2), .ZeroReg(1), .Bypass(0)) dut_nb (
        .clock(clock), .reset(reset), .enable_reg_fetch(enable_reg_fetch),
        .read_addr(read_addr), .read_data(read_data_nb), .read_busy(read_busy_nb),
        .enable_reg_write(enable_reg_write), .do_reg_write(do_reg_write),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .mark_busy(mark_busy), .mark_addr(mark_addr), .busy_vec(busy_vec_nb)
    );

    task automatic check(input string n, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic clr();
        enable_reg_fetch = 1'b0;
        read_addr        = '0;
        enable_reg_write = 1'b0;
        do_reg_write     = '0;
        write_reg_addr   = '0;
        write_reg_data   = '0;
        mark_busy        = 1'b0;
        mark_addr        = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        clr();
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        enable_reg_write         = 1'b1;
        do_reg_write[p]          = 1'b1;
        write_reg_addr[p*5 +: 5] = a;
        write_reg_data[p*32 +: 32] = d;
    endtask

    task automatic mark(input logic [4:0] a);
        mark_busy = 1'b1;
        mark_addr = a;
    endtask

    // Issue a fetch and queue hand-computed results for both instances.
    task automatic fetch(input string n, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2, input logic [2:0] b,
                         input bit nb_chk, input logic [31:0] nd0, input logic [2:0] nb);
        exp_t e;
        enable_reg_fetch = 1'b1;
        read_addr = {a2, a1, a0};
        e.name = n; e.d = {d2, d1, d0}; e.b = b; e.chk = 1'b1;
        q_byp.push_back(e);
        e.name = {n, "_nb"}; e.d = {d2, d1, nd0}; e.b = nb; e.chk = nb_chk;
        q_nb.push_back(e);
    endtask

    always @(posedge clock or posedge reset)
        if (reset) fq <= 1'b0;
        else       fq <= enable_reg_fetch;

    always @(negedge clock) begin
        exp_t e;
        if (fq) begin
            if (q_byp.size() == 0 || q_nb.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                e = q_byp.pop_front();
                check({e.name, "_data"}, read_data, e.d);
                check({e.name, "_busy"}, {93'd0, read_busy}, {93'd0, e.b});
                e = q_nb.pop_front();
                if (e.chk) begin
                    check({e.name, "_data"}, read_data_nb, e.d);
                    check({e.name, "_busy"}, {93'd0, read_busy_nb}, {93'd0, e.b});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        #1;
        check("rst_data", read_data, 96'd0);
        check("rst_busy_vec", {64'd0, busy_vec}, 96'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        fetch("rst_fetch", 5'd1, 5'd2, 5'd3, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        tick();
        check("rst_busy_vec2", {64'd0, busy_vec}, 96'd0);

        // Dual write to r5: port 1 wins.
        wr(0, 5'd5, 32'hDEADBEEF);
        wr(1, 5'd5, 32'h12345678);
        tick();
        fetch("prio_r5", 5'd5, 5'd0, 5'd0, 32'h12345678, 0, 0, 3'b000, 1, 32'h12345678, 3'b000);
        tick();

        // Same-cycle write and fetch of r7.
        wr(0, 5'd7, 32'hA5A5A5A5);
        fetch("byp_r7", 5'd7, 5'd0, 5'd0, 32'hA5A5A5A5, 0, 0, 3'b000, 1, 32'h0, 3'b000);
        tick();
        fetch("after_r7", 5'd7, 5'd5, 5'd0, 32'hA5A5A5A5, 32'h12345678, 0, 3'b000,
              1, 32'hA5A5A5A5, 3'b000);
        tick();

        // Busy scoreboard on r9.
        mark(5'd9);
        tick();
        check("busy_vec_r9", {64'd0, busy_vec}, {64'd0, 32'h0000_0200});
        fetch("busy_r9", 5'd9, 5'd0, 5'd0, 0, 0, 0, 3'b001, 1, 0, 3'b001);
        tick();
        wr(1, 5'd9, 32'h55);
        mark(5'd9);
        fetch("mark_wins_r9", 5'd9, 5'd0, 5'd0, 32'h55, 0, 0, 3'b001, 0, 0, 3'b000);
        tick();
        check("busy_vec_r9_kept", {64'd0, busy_vec}, {64'd0, 32'h0000_0200});
        wr(0, 5'd9, 32'h55);
        fetch("clear_r9", 5'd9, 5'd0, 5'd0, 32'h55, 0, 0, 3'b000, 0, 0, 3'b000);
        tick();
        check("busy_vec_r9_clr", {64'd0, busy_vec}, 96'd0);
        fetch("hold_r9", 5'd0, 5'd9, 5'd0, 0, 32'h55, 0, 3'b000, 1, 0, 3'b000);
        tick();

        // Mark and fetch the same cycle on port 2 sees next-state busy.
        mark(5'd12);
        fetch("mark_fetch_r12", 5'd0, 5'd0, 5'd12, 0, 0, 0, 3'b100, 0, 0, 3'b000);
        tick();

        // Register 0 ignores writes and marks.
        wr(1, 5'd0, 32'hFFFFFFFF);
        mark(5'd0);
        fetch("zero_byp", 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        tick();
        check("busy_vec_r0", {64'd0, busy_vec}, {64'd0, 32'h0000_1000});
        fetch("zero_r0", 5'd0, 5'd7, 5'd0, 0, 32'hA5A5A5A5, 0, 3'b000, 1, 0, 3'b000);
        tick();

        // Asynchronous reset between edges.
        wr(1, 5'd3, 32'h11);
        tick();
        mark(5'd4);
        fetch("pre_rst_r3", 5'd3, 5'd0, 5'd0, 32'h11, 0, 0, 3'b000, 1, 32'h11, 3'b000);
        tick();
        check("pre_rst_busy_vec", {64'd0, busy_vec}, {64'd0, 32'h0000_1010});
        #2 reset = 1'b1;
        #1;
        check("async_rst_data", read_data, 96'd0);
        check("async_rst_busy_vec", {64'd0, busy_vec}, 96'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fetch("post_rst", 5'd3, 5'd5, 5'd9, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
